// File: rtl/smm_pkg.sv
// rtl/smm_pkg.sv - shared scheduler state enum and sizing constants
package smm_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPARE = 2'd2,
        S_DRAIN   = 2'd3
    } sched_state_t;

    localparam int LANES = 4;
    localparam int IDX_W = 16;

endpackage

// File: rtl/lane_rr_counter.sv
// rtl/lane_rr_counter.sv - round-robin lane selector with shared address and end-of-storage detect
module lane_rr_counter
    import smm_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     advance,
    output logic [$clog2(LANES)-1:0] lane_sel,
    output logic [$clog2(DEPTH)-1:0] lane_addr,
    output logic                     at_end
);

    localparam int SW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);

    logic [SW-1:0] sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;

    // Lane rotates every beat; the address moves on once the last lane has been written.
    always_comb begin
        sel_d  = sel_q;
        addr_d = addr_q;
        if (clear) begin
            sel_d  = '0;
            addr_d = '0;
        end else if (advance) begin
            sel_d = sel_q + SW'(1);
            if (sel_q == SW'(LANES - 1)) begin
                addr_d = addr_q + AW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q  <= '0;
            addr_q <= '0;
        end else begin
            sel_q  <= sel_d;
            addr_q <= addr_d;
        end
    end

    assign lane_sel  = sel_q;
    assign lane_addr = addr_q;
    assign at_end    = (sel_q == SW'(LANES - 1)) && (addr_q == AW'(DEPTH - 1));

endmodule

// File: rtl/pic_scheduler.sv
// rtl/pic_scheduler.sv - loads row beats into 4 BRAM lanes then replays them to the PIC units; SCHED_STATS_EN adds stall_cnt
module pic_scheduler
    import smm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     row_valid,
    input  logic                     row_last,
    output logic                     row_ready,
    output logic [LANES-1:0]         lane_we,
    output logic [$clog2(DEPTH)-1:0] lane_addr,
    output logic                     pic_write,
    output logic                     pic_read,
    output logic                     busy,
    output logic                     done,
`ifdef SCHED_STATS_EN
    output logic [IDX_W-1:0]         stall_cnt,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int SW = $clog2(LANES);

    sched_state_t  state_q, state_d;
    logic          ovf_q, ovf_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;
    logic          drain_q, drain_d;
    logic          pic_write_q, pic_write_d;
    logic          pic_read_q, pic_read_d;
    logic          done_q, done_d;

    logic          cnt_clear;
    logic          cnt_adv;
    logic [SW-1:0] cnt_sel;
    logic [AW-1:0] cnt_addr;
    logic          cnt_end;

    lane_rr_counter #(.DEPTH(DEPTH)) u_lane_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .advance   (cnt_adv),
        .lane_sel  (cnt_sel),
        .lane_addr (cnt_addr),
        .at_end    (cnt_end)
    );

    // Job sequencing: next state, lane writes during LOAD, address replay and strobes afterwards.
    always_comb begin
        state_d     = state_q;
        ovf_d       = ovf_q;
        fill_d      = fill_q;
        cmp_addr_d  = cmp_addr_q;
        drain_d     = drain_q;
        pic_write_d = 1'b0;
        pic_read_d  = 1'b0;
        done_d      = 1'b0;
        cnt_clear   = 1'b0;
        cnt_adv     = 1'b0;
        row_ready   = 1'b0;
        lane_we     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    ovf_d     = 1'b0;
                    fill_d    = '0;
                    cnt_clear = 1'b1;
                end
            end
            S_LOAD: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    // Once storage is exhausted, beats are still consumed but never written.
                    if (!ovf_q) begin
                        lane_we = LANES'(1) << cnt_sel;
                        cnt_adv = 1'b1;
                        if (cnt_end && !row_last) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (row_last) begin
                        state_d    = S_COMPARE;
                        cmp_addr_d = '0;
                        fill_d     = ovf_q ? FW'(DEPTH) : ({1'b0, cnt_addr} + FW'(1));
                    end
                end
            end
            S_COMPARE: begin
                // BRAM data appears one cycle after its address, so the load strobe trails by one.
                pic_write_d = 1'b1;
                if ({1'b0, cmp_addr_q} == fill_q - FW'(1)) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cmp_addr_d = cmp_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (!drain_q) begin
                    drain_d    = 1'b1;
                    pic_read_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        lane_addr = (state_q == S_COMPARE) ? cmp_addr_q : cnt_addr;
    end

    // State and registered strobes; reset abandons the job without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ovf_q       <= 1'b0;
            fill_q      <= '0;
            cmp_addr_q  <= '0;
            drain_q     <= 1'b0;
            pic_write_q <= 1'b0;
            pic_read_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            fill_q      <= fill_d;
            cmp_addr_q  <= cmp_addr_d;
            drain_q     <= drain_d;
            pic_write_q <= pic_write_d;
            pic_read_q  <= pic_read_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign pic_write = pic_write_q;
    assign pic_read  = pic_read_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

`ifdef SCHED_STATS_EN
    logic [IDX_W-1:0] stall_q, stall_d;

    // Count LOAD cycles that carry no beat, saturating; a new job clears the count.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == S_LOAD && !row_valid && stall_q != '1) begin
            stall_d = stall_q + IDX_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pic_scheduler.sv
// tb/tb_pic_scheduler.sv - self-checking bench for pic_scheduler
module tb_pic_scheduler;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CAP   = 4 * DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          row_valid;
    logic          row_last;
    logic          row_ready;
    logic [3:0]    lane_we;
    logic [AW-1:0] lane_addr;
    logic          pic_write;
    logic          pic_read;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef SCHED_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pic_scheduler #(.DEPTH(DEPTH), .LANES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .row_valid (row_valid),
        .row_last  (row_last),
        .row_ready (row_ready),
        .lane_we   (lane_we),
        .lane_addr (lane_addr),
        .pic_write (pic_write),
        .pic_read  (pic_read),
        .busy      (busy),
        .done      (done),
`ifdef SCHED_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .overflow  (overflow)
    );

    typedef struct {
        int nb;
        int mode;
        int noise;
        int fill;
        int ovf;
    } job_t;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, int'(row_ready), 0);
        chk({tag, "_we"},    int'(lane_we),   0);
        chk({tag, "_addr"},  int'(lane_addr), 0);
        chk({tag, "_pw"},    int'(pic_write), 0);
        chk({tag, "_pr"},    int'(pic_read),  0);
        chk({tag, "_busy"},  int'(busy),      0);
        chk({tag, "_done"},  int'(done),      0);
        chk({tag, "_ovf"},   int'(overflow),  0);
    endtask

    // mode 0: back-to-back, 1: valid on alternate cycles, 2: random gaps.
    // Model: beat i lands on lane i%4 at address i/4 while i < 4*DEPTH; timing
    // counted from the cycle that accepts row_last.
    task automatic run_job(input int nb, input int mode, input int noise,
                           input int exp_fill, input int exp_ovf);
        int  i      = 0;
        int  cyc    = 0;
        int  stalls = 0;
        bit  v;
        @(posedge clk); #1;
        start     = 1'b1;
        row_valid = 1'($urandom_range(0, 1));
        row_last  = 1'b0;
        @(negedge clk);
        chk("idle_busy",  int'(busy),      0);
        chk("idle_ready", int'(row_ready), 0);
        chk("idle_we",    int'(lane_we),   0);
        while (i < nb) begin
            @(posedge clk); #1;
            start = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            row_valid = v;
            row_last  = v && (i == nb - 1);
            @(negedge clk);
            chk("load_busy",  int'(busy),      1);
            chk("load_ready", int'(row_ready), 1);
            chk("load_ovf",   int'(overflow),  int'(i >= CAP));
            chk("load_pw",    int'(pic_write), 0);
            if (v && i < CAP) begin
                chk("lane_we",   int'(lane_we),   1 << (i % 4));
                chk("lane_addr", int'(lane_addr), i / 4);
            end else begin
                chk("lane_we_off", int'(lane_we), 0);
            end
            if (!v) stalls++;
            if (v) i++;
            cyc++;
            if (cyc > 2000) begin
                chk("load_timeout", 0, 1);
                break;
            end
        end
        for (int k = 1; k <= exp_fill + 3; k++) begin
            @(posedge clk); #1;
            start     = (noise != 0 && k <= exp_fill + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            row_valid = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            row_last  = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (k <= exp_fill) chk("cmp_addr", int'(lane_addr), k - 1);
            chk("cmp_we",    int'(lane_we),   0);
            chk("cmp_ready", int'(row_ready), 0);
            chk("pic_write", int'(pic_write), int'(k >= 2 && k <= exp_fill + 1));
            chk("pic_read",  int'(pic_read),  int'(k == exp_fill + 2));
            chk("done",      int'(done),      int'(k == exp_fill + 3));
            chk("cmp_busy",  int'(busy),      int'(k <= exp_fill + 2));
        end
        chk("ovf_end", int'(overflow), exp_ovf);
`ifdef SCHED_STATS_EN
        chk("stall_cnt", int'(stall_cnt), stalls);
`endif
        @(posedge clk); #1;
        start     = 1'b0;
        row_valid = 1'b0;
        row_last  = 1'b0;
        @(negedge clk);
        chk("done_once", int'(done), 0);
        chk("idle_after", int'(busy), 0);
    endtask

    job_t vec[8];

    initial begin
        vec[0] = '{8,  0, 0, 2,  0};
        vec[1] = '{4,  1, 0, 1,  0};
        vec[2] = '{70, 0, 0, 16, 1};
        vec[3] = '{1,  0, 0, 1,  0};
        vec[4] = '{8,  0, 1, 2,  0};
        vec[5] = '{64, 0, 0, 16, 0};
        vec[6] = '{65, 0, 0, 16, 1};
        vec[7] = '{5,  1, 1, 2,  0};

        reset     = 1'b1;
        start     = 1'b0;
        row_valid = 1'b0;
        row_last  = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        row_valid = 1'b1;
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk); #1;
        reset     = 1'b0;
        start     = 1'b0;
        row_valid = 1'b0;

        for (int t = 0; t < 8; t++) begin
            run_job(vec[t].nb, vec[t].mode, vec[t].noise, vec[t].fill, vec[t].ovf);
        end

        // Reset in the middle of the replay while address 3 is on the bus.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        row_valid = 1'b1;
        for (int b = 0; b < 16; b++) begin
            row_last = (b == 15);
            @(posedge clk); #1;
        end
        row_valid = 1'b0;
        row_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_addr", int'(lane_addr), 3);
        chk("mid_busy", int'(busy), 1);
        #1 reset = 1'b1;
        #1 chk_all_zero("async");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        run_job(8, 0, 0, 2, 0);

        for (int r = 0; r < 6; r++) begin
            int nb;
            int f;
            nb = int'($urandom_range(1, 72));
            f  = (nb + 3) / 4;
            if (f > DEPTH) f = DEPTH;
            run_job(nb, 2, 1, f, int'(nb > CAP));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
